// File: rtl/pc_sequencer_if.sv
// Decoder-to-sequencer bundle: control fields in, pc and gated strobes out.
// IN handshake: ioInValid is a level; a capture happens on its rising edge while
// waiting on IN, and ioAck pulses for exactly that one cycle.
interface pc_sequencer_if #(
  parameter int ADDR_W  = 10,
  parameter int COUNT_W = 16
);
  logic [3:0]         muxPC;
  logic               writeEnableRegs;
  logic               writeEnableData;
  logic               readEnableData;
  logic               branchFlag;
  logic [ADDR_W-1:0]  target;
  logic               ioInValid;
  logic               resume;
  logic [ADDR_W-1:0]  pc;
  logic               regWrite;
  logic               memWrite;
  logic               ioAck;
  logic               halted;
  logic               stall;
  logic [COUNT_W-1:0] retired;
  logic [1:0]         state;

  modport master (
    output muxPC, writeEnableRegs, writeEnableData, readEnableData,
           branchFlag, target, ioInValid, resume,
    input  pc, regWrite, memWrite, ioAck, halted, stall, retired, state
  );

  modport slave (
    input  muxPC, writeEnableRegs, writeEnableData, readEnableData,
           branchFlag, target, ioInValid, resume,
    output pc, regWrite, memWrite, ioAck, halted, stall, retired, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and instruction-cycle sequencer: load wait, IN wait, halt/resume,
// commit-once write strobes and a saturating retired-instruction counter.
module pc_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0,
  parameter int COUNT_W  = 16
) (
  input  logic           clock,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    IO_WAIT  = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
  logic [COUNT_W-1:0]  retired_q;
  logic                io_prev_q;
  logic                retire;
  logic                reg_write, mem_write, io_ack;

  assign pc_inc = pc_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= ADDR_W'(RESET_PC);
      retired_q <= '0;
      io_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      io_prev_q <= bus.ioInValid;
      if (retire && (retired_q != {COUNT_W{1'b1}}))
        retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retire    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    io_ack    = 1'b0;
    case (state_q)
      RUN: begin
        case (bus.muxPC)
          4'd2: begin
            pc_d   = bus.branchFlag ? bus.target : pc_inc;
            retire = 1'b1;
          end
          4'd3: begin
            pc_d   = bus.target;
            retire = 1'b1;
          end
          4'd4: begin
            state_d = HALTED;
            retire  = 1'b1;
          end
          4'd5: state_d = IO_WAIT;
          default: begin
            // Loads hold pc so the decoder fields stay valid through MEM_WAIT.
            if (bus.readEnableData) begin
              state_d = MEM_WAIT;
            end else begin
              pc_d      = pc_inc;
              reg_write = bus.writeEnableRegs;
              mem_write = bus.writeEnableData;
              retire    = 1'b1;
            end
          end
        endcase
      end
      MEM_WAIT: begin
        reg_write = bus.writeEnableRegs;
        pc_d      = pc_inc;
        retire    = 1'b1;
        state_d   = RUN;
      end
      IO_WAIT: begin
        if (bus.ioInValid && !io_prev_q) begin
          reg_write = 1'b1;
          io_ack    = 1'b1;
          pc_d      = pc_inc;
          retire    = 1'b1;
          state_d   = RUN;
        end
      end
      HALTED: begin
        if (bus.resume) begin
          pc_d    = pc_inc;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Strobes are forced low while reset is asserted so nothing commits in that cycle.
  assign bus.regWrite = reg_write & ~reset;
  assign bus.memWrite = mem_write & ~reset;
  assign bus.ioAck    = io_ack & ~reset;
  assign bus.halted   = (state_q == HALTED) & ~reset;
  assign bus.stall    = ((state_q == MEM_WAIT) || (state_q == IO_WAIT)) & ~reset;
  assign bus.pc       = pc_q;
  assign bus.retired  = retired_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: linear steps with hand-computed pc/retired/strobes.
module tb_pc_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  pc_sequencer_if #(.ADDR_W(10), .COUNT_W(16)) bus ();

  pc_sequencer #(.ADDR_W(10), .RESET_PC(0), .COUNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ctrl(input logic [3:0] mux, input logic wer, input logic wed,
                          input logic red);
    bus.muxPC           = mux;
    bus.writeEnableRegs = wer;
    bus.writeEnableData = wed;
    bus.readEnableData  = red;
  endtask

  initial begin
    set_ctrl(4'd1, 1'b0, 1'b0, 1'b0);
    bus.branchFlag = 1'b0;
    bus.target     = '0;
    bus.ioInValid  = 1'b0;
    bus.resume     = 1'b0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_pc", bus.pc, 0);
    check("reset_retired", bus.retired, 0);
    check("reset_state", bus.state, 0);
    check("reset_stall", bus.stall, 0);
    check("reset_halted", bus.halted, 0);
    check("reset_regwrite", bus.regWrite, 0);

    // Sequential execution with register writes
    set_ctrl(4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("seq_pc", bus.pc, i);
      check("seq_regwrite", bus.regWrite, 1);
      tick();
    end
    check("seq_pc_end", bus.pc, 3);
    check("seq_retired", bus.retired, 3);
    set_ctrl(4'd1, 1'b0, 1'b0, 1'b0);
    tick();
    check("seq_pc4", bus.pc, 4);

    // Load: one wait cycle, single commit
    set_ctrl(4'd1, 1'b1, 1'b0, 1'b1);
    #1;
    check("load_c1_regwrite", bus.regWrite, 0);
    tick();
    check("load_c2_stall", bus.stall, 1);
    check("load_c2_regwrite", bus.regWrite, 1);
    check("load_c2_pc", bus.pc, 4);
    check("load_c2_retired", bus.retired, 4);
    tick();
    check("load_pc", bus.pc, 5);
    check("load_retired", bus.retired, 5);
    check("load_stall_off", bus.stall, 0);
    check("load_regwrite_off", bus.regWrite, 0);
    set_ctrl(4'd1, 1'b0, 1'b0, 1'b0);

    // Branches and jumps
    set_ctrl(4'd3, 1'b0, 1'b0, 1'b0);
    bus.target = 10'd7;
    tick();
    check("jump_pc7", bus.pc, 7);
    set_ctrl(4'd2, 1'b1, 1'b1, 1'b0);
    bus.target     = 10'd20;
    bus.branchFlag = 1'b1;
    #1;
    check("branch_regwrite", bus.regWrite, 0);
    check("branch_memwrite", bus.memWrite, 0);
    tick();
    check("branch_taken_pc", bus.pc, 20);
    check("branch_taken_retired", bus.retired, 7);
    set_ctrl(4'd3, 1'b0, 1'b0, 1'b0);
    bus.target = 10'd7;
    tick();
    set_ctrl(4'd2, 1'b0, 1'b0, 1'b0);
    bus.target     = 10'd20;
    bus.branchFlag = 1'b0;
    tick();
    check("branch_not_taken_pc", bus.pc, 8);
    check("branch_nt_retired", bus.retired, 9);
    set_ctrl(4'd3, 1'b0, 1'b0, 1'b0);
    bus.target = 10'd1023;
    tick();
    check("jump_max_pc", bus.pc, 1023);
    set_ctrl(4'd1, 1'b0, 1'b1, 1'b0);
    #1;
    check("store_memwrite", bus.memWrite, 1);
    tick();
    check("wrap_pc", bus.pc, 0);
    check("wrap_retired", bus.retired, 11);
    set_ctrl(4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("illegal0_pc", bus.pc, 1);
    set_ctrl(4'd9, 1'b0, 1'b0, 1'b0);
    tick();
    check("illegal9_pc", bus.pc, 2);
    set_ctrl(4'd3, 1'b0, 1'b0, 1'b0);
    bus.target = 10'd2;
    tick();
    check("tight_loop_pc", bus.pc, 2);
    check("tight_loop_retired", bus.retired, 14);

    // IN with input already high before entry
    set_ctrl(4'd1, 1'b0, 1'b0, 1'b0);
    bus.ioInValid = 1'b1;
    tick();
    check("pre_in_pc", bus.pc, 3);
    set_ctrl(4'd5, 1'b0, 1'b0, 1'b0);
    #1;
    check("in_entry_stall", bus.stall, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("io_wait_state", bus.state, 2);
      check("io_wait_stall", bus.stall, 1);
      check("io_wait_ack", bus.ioAck, 0);
      check("io_wait_regwrite", bus.regWrite, 0);
      check("io_wait_pc", bus.pc, 3);
      tick();
    end
    bus.ioInValid = 1'b0;
    tick();
    check("io_low_ack", bus.ioAck, 0);
    bus.ioInValid = 1'b1;
    #1;
    check("io_capture_ack", bus.ioAck, 1);
    check("io_capture_regwrite", bus.regWrite, 1);
    tick();
    set_ctrl(4'd1, 1'b0, 1'b0, 1'b0);
    bus.ioInValid = 1'b0;
    #1;
    check("io_after_pc", bus.pc, 4);
    check("io_after_retired", bus.retired, 16);
    check("io_after_stall", bus.stall, 0);
    check("io_after_ack", bus.ioAck, 0);

    // Halt and resume
    set_ctrl(4'd3, 1'b0, 1'b0, 1'b0);
    bus.target = 10'd9;
    tick();
    check("pre_halt_pc", bus.pc, 9);
    set_ctrl(4'd4, 1'b0, 1'b0, 1'b0);
    tick();
    set_ctrl(4'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("halt_flag", bus.halted, 1);
      check("halt_pc", bus.pc, 9);
      check("halt_regwrite", bus.regWrite, 0);
      check("halt_memwrite", bus.memWrite, 0);
      check("halt_retired", bus.retired, 18);
      tick();
    end
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    set_ctrl(4'd1, 1'b0, 1'b0, 1'b0);
    #1;
    check("resume_pc", bus.pc, 10);
    check("resume_halted", bus.halted, 0);
    check("resume_retired", bus.retired, 18);

    // Reset while waiting on IN
    set_ctrl(4'd5, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_rst_io_state", bus.state, 2);
    reset = 1'b1;
    #1;
    check("rst_io_stall", bus.stall, 0);
    tick();
    reset = 1'b0;
    set_ctrl(4'd1, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_io_pc", bus.pc, 0);
    check("rst_io_state", bus.state, 0);
    check("rst_io_retired", bus.retired, 0);
    check("rst_io_stall_after", bus.stall, 0);

    // Reset while halted
    tick();
    set_ctrl(4'd4, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_rst_halt", bus.halted, 1);
    check("pre_rst_halt_pc", bus.pc, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_ctrl(4'd1, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_halt_pc", bus.pc, 0);
    check("rst_halt_state", bus.state, 0);
    check("rst_halt_retired", bus.retired, 0);
    check("rst_halt_halted", bus.halted, 0);
    check("rst_halt_regwrite", bus.regWrite, 0);
    check("rst_halt_memwrite", bus.memWrite, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
